uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter NBIT_DATA, default 8, SHALL set the number of data bits per frame.
REQ-002 Parameter NUM_TICKS, default 16, SHALL set the number of tick pulses per bit (oversampling factor); it SHALL be even and at least 4.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL change only on rising clk.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-005 Port tick, input, 1 bit, SHALL be the baud-rate-generator enable, one clk cycle wide, NUM_TICKS per bit time.
REQ-006 Port rx_bit, input, 1 bit, SHALL be the asynchronous serial line; it idles at 1.
REQ-007 Port rd, input, 1 bit, SHALL be the consumer's acknowledge that data_out has been read.
REQ-008 Port data_out, output, NBIT_DATA bits, SHALL hold the last good received byte.
REQ-009 Port data_valid, output, 1 bit, SHALL flag that data_out is unread.
REQ-010 Port rx_done_tick, output, 1 bit, SHALL pulse for one clk cycle when a good frame completes.
REQ-011 Port frame_error, output, 1 bit, SHALL pulse for one clk cycle when the stop bit samples 0.
REQ-012 Port overrun, output, 1 bit, SHALL be a sticky flag set when a good frame completes while data_valid=1.

Function
REQ-013 rx_bit SHALL pass through a 2-flop synchronizer before use; all later references to rx mean the synchronized value.
REQ-014 The FSM SHALL have the states IDLE, START, DATA and STOP; the tick counter and bit counter SHALL advance only in cycles where tick=1.
REQ-015 IDLE: on tick with rx=0, the FSM SHALL go to START and clear the tick counter.
REQ-016 START: at tick counter NUM_TICKS/2-1 (mid start bit), if rx=0, the FSM SHALL go to DATA and clear both counters; if rx=1, it SHALL treat the event as a glitch and return to IDLE with no output activity.
REQ-017 DATA: at tick counter NUM_TICKS-1, the block SHALL sample rx into the shift register, data LSB first (shift right, insert at MSB), and clear the tick counter.
REQ-018 DATA: after sampling bit NBIT_DATA-1, the FSM SHALL go to STOP; otherwise it SHALL increment the bit counter.
REQ-019 STOP: at tick counter NUM_TICKS-1 with rx=1, the block SHALL load data_out from the shift register, set data_valid, pulse rx_done_tick, and return to IDLE.
REQ-020 STOP: at tick counter NUM_TICKS-1 with rx=0, the block SHALL pulse frame_error, leave data_out and data_valid unchanged, and return to IDLE.
REQ-021 Completion latency SHALL be (NBIT_DATA+1)*NUM_TICKS + NUM_TICKS/2 ticks after the first tick that sees rx=0, plus 2 clk cycles of synchronizer delay.
REQ-022 rd=1 SHALL clear data_valid on the next clk edge.
REQ-023 If rd=1 coincides with a good-frame completion, data_valid SHALL end at 1 and overrun SHALL NOT be set.
REQ-024 On overrun, data_out SHALL be overwritten with the new byte and data_valid SHALL remain 1.
REQ-025 overrun SHALL clear only on reset.
REQ-026 rx transitions between ticks SHALL be ignored.
REQ-027 A falling edge during STOP SHALL have no effect until the FSM reaches IDLE.
REQ-028 An unreachable state encoding SHALL recover to IDLE with both counters cleared.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE and the counters and shift register SHALL be 0.
REQ-030 While reset=1, data_out, data_valid, rx_done_tick, frame_error and overrun SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-031 A reset asserted mid-frame SHALL discard the partial byte; after release, the block SHALL wait for a fresh falling edge.

Structure
REQ-032 The state encodings (IDLE=00, START=01, DATA=10, STOP=11) and the NBIT_DATA/NUM_TICKS defaults SHALL live in the shared UART package used by the transmitter.
REQ-033 Counter widths SHALL derive from $clog2 of NUM_TICKS and NBIT_DATA.
REQ-034 The synchronizer SHALL be the sub-module uart_sync2, which has reset value 1.

Verification
REQ-035 Send frame 0xF9 at NUM_TICKS=16 -> data_out=0xF9, data_valid=1, one rx_done_tick pulse, 152 ticks (+2 clk) after the start edge.
REQ-036 Drive rx low for 4 ticks, then high -> no rx_done_tick, no frame_error, FSM back in IDLE.
REQ-037 Send 0x3C with stop bit=0 -> one frame_error pulse, data_out and data_valid unchanged from their prior values.
REQ-038 Send back-to-back 0x55 then 0xAA with no rd -> overrun=1, data_out=0xAA; then rd -> data_valid=0, overrun stays 1.
REQ-039 Assert reset at bit 4 of 0xA5 -> all outputs 0; next frame 0x12 is received correctly.
REQ-040 Assert rd in the same cycle as completion of 0x81 while data_valid=1 -> data_valid=1, overrun=0, data_out=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame parameters
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int NBIT_DATA_DEF = 8;
  localparam int NUM_TICKS_DEF = 16;

  // Counter width for a count of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (mark) level so no false start bit is seen coming out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first
// data capture, stop-bit check, and a one-entry output holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NBIT_DATA = NBIT_DATA_DEF,
  parameter int NUM_TICKS = NUM_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx_bit,
  input  logic                 rd,
  output logic [NBIT_DATA-1:0] data_out,
  output logic                 data_valid,
  output logic                 rx_done_tick,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int TW = cnt_width(NUM_TICKS);
  localparam int BW = cnt_width(NBIT_DATA);
  localparam logic [TW-1:0] TICK_MID  = TW'(NUM_TICKS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(NUM_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBIT_DATA - 1);

  uart_state_t          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [NBIT_DATA-1:0] shreg;
  logic                 rx;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_bit),
    .q     (rx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
      // A completing good frame below overrides this read-clear.
      if (rd)
        data_valid <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              if (!rx) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx, shreg[NBIT_DATA-1:1]};
              if (bit_cnt == BIT_LAST)
                state <= STOP;
              else
                bit_cnt <= bit_cnt + BW'(1);
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              state    <= IDLE;
              tick_cnt <= '0;
              if (rx) begin
                data_out     <= shreg;
                data_valid   <= 1'b1;
                rx_done_tick <= 1'b1;
                if (data_valid && !rd)
                  overrun <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame stimulus pushes expected completion
// events, a monitor pops and checks them whenever the receiver reports one.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       rx_bit;
  logic       rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_done_tick;
  logic       frame_error;
  logic       overrun;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         dv;
    bit         ovr;
    int         done_tick;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tick_idx = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx #(.NBIT_DATA(8), .NUM_TICKS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .rx_bit       (rx_bit),
    .rd           (rd),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .rx_done_tick (rx_done_tick),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud enable: one clk-wide pulse every 4 clocks.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  always @(posedge clk) if (tick) tick_idx <= tick_idx + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every reported completion must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (rx_done_tick || frame_error)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: done=%0b ferr=%0b, expected no event",
                 rx_done_tick, frame_error);
      end else begin
        e = sb.pop_front();
        check("event_kind", 32'({rx_done_tick, frame_error}), e.is_err ? 32'd1 : 32'd2);
        check("ev_data_out", 32'(data_out), 32'(e.data));
        check("ev_data_valid", 32'(data_valid), 32'(e.dv));
        check("ev_overrun", 32'(overrun), 32'(e.ovr));
        check("ev_latency_tick", 32'(tick_idx), 32'(e.done_tick));
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (tick !== 1'b1);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    rx_bit = 1'b1;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit rd_at_done,
                            input bit x_err, input logic [7:0] x_data,
                            input bit x_dv, input bit x_ovr);
    int   t0;
    exp_t x;
    wait_tick();
    t0 = tick_idx;
    x.is_err = x_err;
    x.data = x_data;
    x.dv = x_dv;
    x.ovr = x_ovr;
    x.done_tick = t0 + 153;
    sb.push_back(x);
    rx_bit = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 8; i++) begin
      rx_bit = d[i];
      repeat (16) wait_tick();
    end
    rx_bit = stop;
    while (tick_idx < t0 + 152) wait_tick();
    if (rd_at_done) begin
      repeat (4) @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    while (tick_idx < t0 + 160) wait_tick();
    rx_bit = 1'b1;
  endtask

  task automatic read_pulse(input string name);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check(name, 32'(data_valid), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_done_tick", 32'(rx_done_tick), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    rx_bit = 1'b1;
    rd     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    idle_ticks(4);

    // Good frame 0xF9, latency checked by the monitor, then read it.
    send_frame(8'hF9, 1'b1, 1'b0, 1'b0, 8'hF9, 1'b1, 1'b0);
    check("f9_data_valid", 32'(data_valid), 32'd1);
    read_pulse("f9_rd_clears_valid");

    // Short low glitch: rejected at mid start bit.
    wait_tick();
    rx_bit = 1'b0;
    repeat (4) wait_tick();
    idle_ticks(20);
    check("glitch_state_idle", 32'(dut.state), 32'd0);
    check("glitch_data_valid", 32'(data_valid), 32'd0);

    // Frame error leaves the held byte and valid flag untouched.
    send_frame(8'h66, 1'b1, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0);
    idle_ticks(20);
    check("ferr_data_out", 32'(data_out), 32'h66);
    read_pulse("ferr_rd_clears_valid");

    // Back-to-back frames with no read produce a sticky overrun.
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_data_out", 32'(data_out), 32'hAA);
    read_pulse("ovr_rd_clears_valid");
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of bit 4 of 0xA5.
    wait_tick();
    rx_bit = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 4; i++) begin
      rx_bit = 8'hA5 >> i;
      repeat (16) wait_tick();
    end
    rx_bit = 1'b0;
    repeat (8) wait_tick();
    reset = 1'b1;
    rx_bit = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_ticks(20);
    check("post_rst_state", 32'(dut.state), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0);

    // Read coincides with completion of 0x81 while 0x12 is still unread.
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0);
    check("rdhit_data_valid", 32'(data_valid), 32'd1);
    check("rdhit_overrun", 32'(overrun), 32'd0);
    check("rdhit_data_out", 32'(data_out), 32'h81);

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
